// File: rtl/des128_pkg.sv
// Shared constants, shift schedule, FSM encoding and permutation helpers for the
// 128-bit expanded DES key schedule.
package des128_pkg;

    localparam int KEY_W  = 128;
    localparam int HALF_W = 56;
    localparam int RK_W   = 96;
    localparam int ROUNDS = 16;

    // Left-shift amount applied when producing round r on the encryption side.
    localparam int unsigned SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (HALF_W - n));
    endfunction

    // PC_1: drop the low (parity) bit of every key byte; upper 56 bits form C0, lower form D0.
    function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [2*HALF_W-1:0] r;
        r = '0;
        for (int b = 0; b < KEY_W/8; b++) r[7*b +: 7] = k[8*b+1 +: 7];
        return r;
    endfunction

    // PC_2 on one half: keep six of every seven bits.
    function automatic logic [RK_W/2-1:0] pc2_half(input logic [HALF_W-1:0] h);
        logic [RK_W/2-1:0] r;
        r = '0;
        for (int g = 0; g < HALF_W/7; g++) r[6*g +: 6] = h[7*g +: 6];
        return r;
    endfunction

    function automatic logic [RK_W-1:0] pc2(input logic [HALF_W-1:0] c, input logic [HALF_W-1:0] d);
        return {pc2_half(c), pc2_half(d)};
    endfunction

endpackage

// File: rtl/round_key_dec_if.sv
// Request/response bundle between the key source, the decryption key schedule and
// the round pipeline.
interface round_key_dec_if;
    import des128_pkg::*;

    logic [KEY_W-1:0] Key_in;
    logic             Start;
    logic             Key_ready;
    logic [RK_W-1:0]  Key_out;
    logic             Key_valid;
    logic [4:0]       Round;
    logic             Busy;
    logic             Done;

    modport master (
        output Key_in, Start, Key_ready,
        input  Key_out, Key_valid, Round, Busy, Done
    );

    modport slave (
        input  Key_in, Start, Key_ready,
        output Key_out, Key_valid, Round, Busy, Done
    );
endinterface

// File: rtl/round_key_dec_ctrl.sv
// Sequencing for the decryption key schedule: IDLE/RUN/DONE FSM, round counter
// and valid/ready handshake.
module round_key_dec_ctrl
    import des128_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Key_ready,
    output logic       load,
    output logic       step,
    output logic       Key_valid,
    output logic       Busy,
    output logic       Done,
    output logic [4:0] Round
);
    state_t state_q, state_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (Key_ready && Round == 5'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Key_valid = (state_q == RUN);
        Busy      = (state_q != IDLE);
        Done      = (state_q == DONE);
        load      = (state_q == IDLE) && Start;
        step      = Key_valid && Key_ready && (Round > 5'd1);
    end

    // Round holds through a stall and through the K1 acceptance, clearing on leaving DONE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                Round <= 5'd0;
        else if (load)            Round <= 5'd16;
        else if (step)            Round <= Round - 5'd1;
        else if (state_q == DONE) Round <= 5'd0;
    end

endmodule

// File: rtl/round_key_dec.sv
// Decryption key schedule: regenerates C16/D16 from the cipher key and walks back
// to C1/D1 with right rotations, emitting K16..K1.
module round_key_dec
    import des128_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    round_key_dec_if.slave kif
);
    logic [HALF_W-1:0]   c_q, d_q;
    logic [2*HALF_W-1:0] cd0;
    logic                load, step;
    int unsigned         sh;

    round_key_dec_ctrl u_ctrl (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (kif.Start),
        .Key_ready (kif.Key_ready),
        .load      (load),
        .step      (step),
        .Key_valid (kif.Key_valid),
        .Busy      (kif.Busy),
        .Done      (kif.Done),
        .Round     (kif.Round)
    );

    assign cd0 = pc1(kif.Key_in);
    assign sh  = SHIFT_SCHED[kif.Round];

    // Total encryption shift is 28, so C16/D16 come straight from C0/D0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            c_q <= '0;
            d_q <= '0;
        end else if (load) begin
            c_q <= rotl(cd0[2*HALF_W-1:HALF_W], 28);
            d_q <= rotl(cd0[HALF_W-1:0], 28);
        end else if (step) begin
            c_q <= rotr(c_q, sh);
            d_q <= rotr(d_q, sh);
        end
    end

    assign kif.Key_out = pc2(c_q, d_q);

endmodule

// File: tb/tb_round_key_dec.sv
// Directed bench for round_key_dec: key table, stall, ignored restart, async reset
// and back-to-back schedules against a forward encryption-schedule model.
module tb_round_key_dec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_key_dec_if kif ();
    round_key_dec dut (.Clk(clk), .Reset(rst), .kif(kif));

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] KEY_B = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

    typedef struct {
        logic [127:0] key;
        logic [95:0]  k16;
        logic [95:0]  k1;
    } vec_t;

    vec_t vecs [5];

    int sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] m_rotl(input logic [55:0] x, input int n);
        logic [111:0] d;
        d = {x, x};
        return d[111-n -: 56];
    endfunction

    function automatic logic [111:0] m_pc1(input logic [127:0] k);
        logic [111:0] o;
        for (int i = 0; i < 112; i++) o[i] = k[(i/7)*8 + (i%7) + 1];
        return o;
    endfunction

    function automatic logic [47:0] m_pc2h(input logic [55:0] h);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[i] = h[(i/6)*7 + (i%6)];
        return o;
    endfunction

    // Forward (encryption-side) key r: cumulative left rotation of C0/D0.
    function automatic logic [95:0] m_key(input logic [127:0] k, input int r);
        logic [111:0] cd;
        int cum;
        cd  = m_pc1(k);
        cum = 0;
        for (int j = 0; j < r; j++) cum += sched[j];
        return {m_pc2h(m_rotl(cd[111:56], cum % 56)), m_pc2h(m_rotl(cd[55:0], cum % 56))};
    endfunction

    // One schedule with Key_ready high except for stall_n cycles at stall_at;
    // Start with an all-ones key is pulsed when the key on the bus is restart_at.
    task automatic run_keys(input logic [127:0] key, input int stall_at, input int stall_n,
                            input int restart_at, output logic [95:0] first, output logic [95:0] last);
        int r, rr, stalled, cyc;
        logic [111:0] cd;
        first = '0;
        last  = '0;
        kif.Key_in    = key;
        kif.Start     = 1'b1;
        kif.Key_ready = 1'b1;
        tick;
        kif.Start = 1'b0;
        r = 16; stalled = 0; cyc = 1;
        while (r >= 1 && cyc < 40) begin
            chk("run_valid", 128'(kif.Key_valid), 128'(1));
            chk("run_busy",  128'(kif.Busy),      128'(1));
            chk("run_round", 128'(kif.Round),     128'(r));
            chk("run_key",   128'(kif.Key_out),   128'(m_key(key, r)));
            if (r == 16) first = kif.Key_out;
            if (r == 1)  last  = kif.Key_out;
            rr = r;
            if (r == stall_at && stalled < stall_n) begin
                kif.Key_ready = 1'b0;
                stalled++;
            end else begin
                kif.Key_ready = 1'b1;
                r--;
            end
            if (rr == restart_at) begin
                kif.Start  = 1'b1;
                kif.Key_in = '1;
            end
            tick;
            cyc++;
            kif.Start = 1'b0;
        end
        chk("run_bounded", 128'(r), 128'(0));
        chk("done_cycle",  128'(cyc),           128'(17 + stall_n));
        chk("done_pulse",  128'(kif.Done),      128'(1));
        chk("done_valid",  128'(kif.Key_valid), 128'(0));
        chk("done_busy",   128'(kif.Busy),      128'(1));
        cd = m_pc1(key);
        chk("c_after_k1",  128'(dut.c_q), 128'(m_rotl(cd[111:56], 1)));
        chk("d_after_k1",  128'(dut.d_q), 128'(m_rotl(cd[55:0], 1)));
        tick;
        chk("idle_done",  128'(kif.Done),  128'(0));
        chk("idle_busy",  128'(kif.Busy),  128'(0));
        chk("idle_round", 128'(kif.Round), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] k16_got, k1_got;
        int t_k1, t_k16b, seen_done;

        vecs[0] = '{128'h0, 96'h0, 96'h0};
        vecs[1] = '{128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, 96'hFFFFFFFFFFFFFFFFFFFFFFFF, 96'hFFFFFFFFFFFFFFFFFFFFFFFF};
        vecs[2] = '{128'h0101010101010101_0101010101010101, 96'h0, 96'h0};
        vecs[3] = '{128'hFEFEFEFEFEFEFEFE_FEFEFEFEFEFEFEFE, 96'hFFFFFFFFFFFFFFFFFFFFFFFF, 96'hFFFFFFFFFFFFFFFFFFFFFFFF};
        vecs[4] = '{KEY_A, m_key(KEY_A, 16), m_key(KEY_A, 1)};

        rst = 1'b1;
        kif.Key_in = '0; kif.Start = 1'b0; kif.Key_ready = 1'b0;
        tick; tick;
        chk("rst_valid", 128'(kif.Key_valid), 128'(0));
        chk("rst_busy",  128'(kif.Busy),      128'(0));
        chk("rst_done",  128'(kif.Done),      128'(0));
        chk("rst_round", 128'(kif.Round),     128'(0));
        chk("rst_key",   128'(kif.Key_out),   128'(0));
        rst = 1'b0;

        // Key_ready without a schedule does nothing.
        kif.Key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_ready_round", 128'(kif.Round),     128'(0));
            chk("idle_ready_valid", 128'(kif.Key_valid), 128'(0));
        end

        for (int v = 0; v < 5; v++) begin
            run_keys(vecs[v].key, -1, 0, -1, k16_got, k1_got);
            chk($sformatf("vec%0d_k16", v), 128'(k16_got), 128'(vecs[v].k16));
            chk($sformatf("vec%0d_k1", v),  128'(k1_got),  128'(vecs[v].k1));
        end

        // Three-cycle stall at round 10.
        run_keys(KEY_A, 10, 3, -1, k16_got, k1_got);
        // Start with a different key at round 12 is ignored.
        run_keys(KEY_A, -1, 0, 12, k16_got, k1_got);

        // Asynchronous reset at round 7.
        kif.Key_in = KEY_A; kif.Start = 1'b1; kif.Key_ready = 1'b1;
        tick;
        kif.Start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        chk("pre_rst_round", 128'(kif.Round), 128'(7));
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 128'(kif.Key_valid), 128'(0));
        chk("arst_busy",  128'(kif.Busy),      128'(0));
        chk("arst_round", 128'(kif.Round),     128'(0));
        chk("arst_done",  128'(kif.Done),      128'(0));
        chk("arst_key",   128'(kif.Key_out),   128'(0));
        tick; tick;
        chk("arst_hold_done",  128'(kif.Done),      128'(0));
        chk("arst_hold_valid", 128'(kif.Key_valid), 128'(0));
        rst = 1'b0;
        kif.Key_in = KEY_B; kif.Start = 1'b1;
        tick;
        kif.Start = 1'b0;
        chk("post_rst_valid", 128'(kif.Key_valid), 128'(1));
        chk("post_rst_round", 128'(kif.Round),     128'(16));
        chk("post_rst_k16",   128'(kif.Key_out),   128'(m_key(KEY_B, 16)));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;

        // Back-to-back schedules with Start held high; Key_in switches to B mid-run.
        kif.Key_in = KEY_A; kif.Start = 1'b1; kif.Key_ready = 1'b1;
        tick;
        chk("b2b_first_k16", 128'(kif.Key_out), 128'(m_key(KEY_A, 16)));
        kif.Key_in = KEY_B;
        t_k1 = -1; t_k16b = -1; seen_done = 0;
        for (int c = 1; c < 60 && t_k16b < 0; c++) begin
            if (kif.Done) seen_done = 1;
            if (kif.Key_valid && kif.Round == 5'd1 && !seen_done) t_k1 = c;
            if (kif.Key_valid && kif.Round == 5'd16 && seen_done) begin
                t_k16b = c;
                chk("b2b_second_k16", 128'(kif.Key_out), 128'(m_key(KEY_B, 16)));
            end
            tick;
        end
        chk("b2b_seen", 128'(t_k16b >= 0), 128'(1));
        chk("b2b_gap",  128'(t_k16b - t_k1), 128'(3));
        kif.Start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
